// File: rtl/counter_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_arbiter_pkg
// Description : Shared types and default widths for the counter arbiter
//               (FSM states, grant encoding, datapath/prescaler widths).
// Revision    : 1.0 - initial release
// ============================================================================
package counter_arbiter_pkg;

    localparam int C_DEFAULT_BITS  = 32;
    localparam int C_DEFAULT_PRE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_WB = 1'b0,
        GNT_LA = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/counter_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : counter_prescaler
// Description : Free-running prescaler. Fires once every prescale+1 cycles;
//               suppress hides the tick but the count still wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_prescaler
    import counter_arbiter_pkg::*;
#(
    parameter int PRE_W = C_DEFAULT_PRE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PRE_W-1:0] prescale,
    input  logic             suppress,
    output logic             tick
);

    logic [PRE_W-1:0] r_count;
    logic             w_fire;

    // Fire on >= so that lowering prescale below the count fires right away
    always_comb begin
        w_fire = (r_count >= prescale);
        tick   = w_fire && !suppress && !reset;
    end

    // Count every cycle, wrapping whenever the period is reached
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_fire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PRE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_arbiter
// Description : Arbitrates a bus port (byte-merged write / read) and a probe
//               port (full load) onto a shared counter datapath, and issues
//               prescaled increment commands. Load always beats increment.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int BITS  = C_DEFAULT_BITS,
    parameter int PRE_W = C_DEFAULT_PRE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [3:0]       wb_wstrb,
    input  logic [BITS-1:0]  wb_wdata,
    output logic             wb_ready,
    output logic [BITS-1:0]  wb_rdata,
    input  logic             la_req,
    input  logic [BITS-1:0]  la_data,
    output logic             la_ack,
    input  logic [PRE_W-1:0] prescale,
    input  logic [BITS-1:0]  cnt_value,
    output logic             cnt_load,
    output logic [BITS-1:0]  cnt_load_val,
    output logic             cnt_inc,
    output logic             busy
);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    grant_t          r_grant;
    grant_t          r_last_grant;
    grant_t          w_grant_nxt;
    logic            w_capture;
    logic [3:0]      r_wstrb;
    logic [BITS-1:0] r_data;
    logic [BITS-1:0] r_rdata;
    logic [BITS-1:0] w_mask;
    logic [BITS-1:0] w_merged;
    logic            w_tick;

    // Expand the captured byte strobes to a bit mask and merge with the live counter
    always_comb begin
        w_mask = '0;
        for (int j = 0; j < BITS; j++) begin
            w_mask[j] = (j < 32) ? r_wstrb[j[4:3]] : 1'b0;
        end
        w_merged = (r_data & w_mask) | (cnt_value & ~w_mask);
    end

    // Next-state, grant decision and transaction outputs; reset silences everything
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_capture    = 1'b0;
        wb_ready     = 1'b0;
        la_ack       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wb_valid || la_req) begin
                    w_state_nxt = ST_SERVE;
                    w_capture   = 1'b1;
                    if (wb_valid && la_req) begin
                        w_grant_nxt = (r_last_grant == GNT_LA) ? GNT_WB : GNT_LA;
                    end else if (wb_valid) begin
                        w_grant_nxt = GNT_WB;
                    end else begin
                        w_grant_nxt = GNT_LA;
                    end
                end
            end
            ST_SERVE: begin
                busy        = 1'b1;
                w_state_nxt = ST_DONE;
                if (r_grant == GNT_WB) begin
                    cnt_load     = |r_wstrb;
                    cnt_load_val = (|r_wstrb) ? w_merged : '0;
                end else begin
                    cnt_load     = 1'b1;
                    cnt_load_val = r_data;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                w_state_nxt = ST_IDLE;
                wb_ready    = (r_grant == GNT_WB);
                la_ack      = (r_grant == GNT_LA);
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (reset) begin
            wb_ready     = 1'b0;
            la_ack       = 1'b0;
            cnt_load     = 1'b0;
            cnt_load_val = '0;
            busy         = 1'b0;
        end
    end

    // State register, request capture on grant and read-data capture in bus SERVE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_LA;
            r_last_grant <= GNT_LA;
            r_wstrb      <= '0;
            r_data       <= '0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_grant      <= w_grant_nxt;
                r_last_grant <= w_grant_nxt;
                if (w_grant_nxt == GNT_WB) begin
                    r_wstrb <= wb_wstrb;
                    r_data  <= wb_wdata;
                end else begin
                    r_wstrb <= '0;
                    r_data  <= la_data;
                end
            end
            if (r_state == ST_SERVE && r_grant == GNT_WB) begin
                r_rdata <= cnt_value;
            end
        end
    end

    assign wb_rdata = r_rdata;
    assign cnt_inc  = w_tick;

    counter_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .prescale (prescale),
        .suppress (cnt_load),
        .tick     (w_tick)
    );

endmodule
`default_nettype wire

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter BITS, default 32, SHALL set the counter datapath width.
REQ-002 Parameter PRE_W, default 8, SHALL set the prescaler width.
REQ-003 clk  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 wb_valid  in  1  SHALL be the bus-side request, held by the requester until wb_ready.
REQ-006 wb_wstrb  in  4  SHALL be the byte write strobes; 4'b0000 means read-only.
REQ-007 wb_wdata  in  BITS  SHALL be the bus write data.
REQ-008 wb_ready  out  1  SHALL be the one-cycle bus completion pulse.
REQ-009 wb_rdata  out  BITS  SHALL be the counter value before the bus access.
REQ-010 la_req  in  1  SHALL be the probe-side load request, held until la_ack.
REQ-011 la_data  in  BITS  SHALL be the probe-side full-width load value.
REQ-012 la_ack  out  1  SHALL be the one-cycle probe completion pulse.
REQ-013 prescale  in  PRE_W  SHALL set the increment period to prescale+1 cycles.
REQ-014 cnt_value  in  BITS  SHALL be the current counter value from the datapath.
REQ-015 cnt_load  out  1  SHALL command a counter load this cycle.
REQ-016 cnt_load_val  out  BITS  SHALL be the load value, valid while cnt_load=1.
REQ-017 cnt_inc  out  1  SHALL command a counter increment this cycle.
REQ-018 busy  out  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-019 FSM SHALL have states IDLE, SERVE and DONE. Transitions: IDLE->SERVE on any request; SERVE->DONE always; DONE->IDLE always.
REQ-020 In IDLE, if only one request is high, that requester SHALL be granted.
REQ-021 In IDLE, if both requests are high, the requester not granted last SHALL win; last_grant resets to LA, so WB wins the first tie.
REQ-022 On grant, the requester's wstrb/wdata or la_data SHALL be captured; later input changes SHALL be ignored for that transaction.
REQ-023 Latency: a request sampled in IDLE at cycle N SHALL give cnt_load in N+1 (SERVE) and ready/ack in N+2 (DONE).
REQ-024 In SERVE for WB, cnt_load_val SHALL merge per byte: wdata byte where wstrb=1, cnt_value byte otherwise. wb_rdata SHALL capture cnt_value.
REQ-025 In SERVE for WB, cnt_load SHALL be 0 if wstrb=4'b0000 (pure read).
REQ-026 In SERVE for LA, cnt_load SHALL be 1 with cnt_load_val=captured la_data. wb_rdata SHALL be unchanged.
REQ-027 In DONE, exactly one of wb_ready/la_ack SHALL be 1 for one cycle; both SHALL be 0 in all other states.
REQ-028 The requester drops its request at the edge where ready/ack is sampled high; a request still high in the following IDLE SHALL start a new transaction.
REQ-029 The prescaler counter SHALL count every cycle. When it is >= prescale, cnt_inc SHALL pulse and the counter SHALL wrap to 0.
REQ-030 prescale=0 SHALL give cnt_inc every cycle. Lowering prescale below the current count SHALL fire on the next cycle.
REQ-031 When cnt_load=1, cnt_inc SHALL be forced 0 (load wins). The prescaler SHALL still wrap and the tick SHALL be lost.
REQ-032 wb_rdata SHALL hold its value until the next WB SERVE.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE, with prescaler=0 and last_grant=LA.
REQ-034 On reset, wb_ready, la_ack, cnt_load, cnt_inc and busy SHALL be 0, and wb_rdata and cnt_load_val SHALL be 0.
REQ-035 Reset in SERVE or DONE SHALL abort the transaction with no ready/ack; the requester must re-issue.

Structure
REQ-036 Package counter_arbiter_pkg SHALL hold the FSM state enum, the grant enum (GNT_WB, GNT_LA) and the BITS/PRE_W defaults.
REQ-037 The prescaler SHALL be the sub-module counter_prescaler (clk, reset, prescale, suppress, tick).

Verification
REQ-038 wb_valid with wstrb=4'hF, wdata=32'hDEADBEEF, cnt_value=5 -> cnt_load=1 with 32'hDEADBEEF at N+1; wb_ready at N+2; wb_rdata=5.
REQ-039 wstrb=4'b0010, wdata=32'h0000AB00, cnt_value=32'h11223344 -> cnt_load_val=32'h1122AB44.
REQ-040 wb_valid and la_req high together twice -> first grant WB, second grant LA; never both acks in one cycle.
REQ-041 prescale=3, no requests -> cnt_inc every 4th cycle; prescale=0 -> every cycle; load on a tick cycle -> cnt_inc=0.
REQ-042 Reset asserted in SERVE -> no la_ack, busy=0 next cycle; re-issued la_req is served normally.
REQ-043 wstrb=0 read -> cnt_load stays 0; wb_rdata=cnt_value; wb_ready at N+2.
